// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared stage state encoding and payload layout for the inter-stage registers
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } stage_state_e;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam int EXT_W   = 32;
    localparam int ALU_W   = 32;
    localparam int HI_W    = 32;
    localparam int LO_W    = 32;
    localparam int FLAG_W  = 1;

    // Fields packed LSB-first; instr sits at bit 0 so an all-zero payload decodes as a nop.
    localparam int INSTR_OFF = 0;
    localparam int PC_OFF    = INSTR_OFF + INSTR_W;
    localparam int EXT_OFF   = PC_OFF + PC_W;
    localparam int ALU_OFF   = EXT_OFF + EXT_W;
    localparam int HI_OFF    = ALU_OFF + ALU_W;
    localparam int LO_OFF    = HI_OFF + HI_W;
    localparam int FLAG_OFF  = LO_OFF + LO_W;

    localparam int W_PAYLOAD_W = FLAG_OFF + FLAG_W;

    localparam logic [W_PAYLOAD_W-1:0] BUBBLE_DEFAULT = '0;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter, cleared only by reset
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline register with one-entry skid buffer and stall counter
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W = W_PAYLOAD_W,
    parameter int                CNT_W  = 16,
    parameter logic [DATA_W-1:0] BUBBLE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_state_e      state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              acc;
    logic              pop;

    // Handshake outputs come only from registered state, breaking both combinational paths.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign acc       = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        occupancy = 2'd0;
        case (state)
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= EMPTY;
            main_q <= BUBBLE;
            skid_q <= BUBBLE;
        end else if (flush) begin
            state  <= EMPTY;
            main_q <= BUBBLE;
            skid_q <= BUBBLE;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        state  <= ONE;
                        main_q <= in_data;
                    end
                end
                ONE: begin
                    if (acc && pop) begin
                        main_q <= in_data;
                    end else if (acc) begin
                        state  <= FULL;
                        skid_q <= in_data;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    // Skid always holds the younger beat, so it moves up behind the popped one.
                    if (pop) begin
                        state  <= ONE;
                        main_q <= skid_q;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (out_valid & ~out_ready),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed vector bench for pipe_stage_skid
module tb_pipe_stage_skid;

    localparam int DW = 193;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        flush;
        logic        in_valid;
        logic [31:0] in_data;
        logic        out_ready;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_ready;
        logic [1:0]  exp_occ;
        logic [3:0]  exp_stall;
    } vec_t;

    vec_t vecs[$];

    pipe_stage_skid #(
        .DATA_W(DW),
        .CNT_W (CW),
        .BUBBLE('0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic f, input logic v, input logic [31:0] d, input logic r,
                       input logic ev, input logic [31:0] ed, input logic er,
                       input logic [1:0] eo, input logic [3:0] es);
        vec_t t;
        t.flush     = f;
        t.in_valid  = v;
        t.in_data   = d;
        t.out_ready = r;
        t.exp_valid = ev;
        t.exp_data  = ed;
        t.exp_ready = er;
        t.exp_occ   = eo;
        t.exp_stall = es;
        vecs.push_back(t);
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [31:0] ed,
                             input logic er, input logic [1:0] eo, input logic [3:0] es);
        check({tag, " out_valid"}, DW'(out_valid), DW'(ev));
        check({tag, " out_data"},  out_data,       DW'(ed));
        check({tag, " in_ready"},  DW'(in_ready),  DW'(er));
        check({tag, " occupancy"}, DW'(occupancy), DW'(eo));
        check({tag, " stall_cnt"}, DW'(stall_cnt), DW'(es));
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // streaming 1..8, one beat per cycle
        for (int i = 1; i <= 8; i++) add(1'b0, 1'b1, 32'(i), 1'b1, 1'b1, 32'(i), 1'b1, 2'd1, 4'd0);
        add(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 1'b1, 2'd0, 4'd0);
        // back-pressure: A, B fill, C held off, then drain in order
        add(1'b0, 1'b1, 32'hA, 1'b0, 1'b1, 32'hA, 1'b1, 2'd1, 4'd0);
        add(1'b0, 1'b1, 32'hB, 1'b0, 1'b1, 32'hA, 1'b0, 2'd2, 4'd1);
        add(1'b0, 1'b1, 32'hC, 1'b0, 1'b1, 32'hA, 1'b0, 2'd2, 4'd2);
        add(1'b0, 1'b1, 32'hC, 1'b0, 1'b1, 32'hA, 1'b0, 2'd2, 4'd3);
        add(1'b0, 1'b1, 32'hC, 1'b0, 1'b1, 32'hA, 1'b0, 2'd2, 4'd4);
        add(1'b0, 1'b1, 32'hC, 1'b1, 1'b1, 32'hB, 1'b1, 2'd1, 4'd4);
        add(1'b0, 1'b1, 32'hC, 1'b1, 1'b1, 32'hC, 1'b1, 2'd1, 4'd4);
        add(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hC, 1'b1, 2'd0, 4'd4);
        // flush while FULL with a beat presented
        add(1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 32'h11, 1'b1, 2'd1, 4'd4);
        add(1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 32'h11, 1'b0, 2'd2, 4'd5);
        add(1'b1, 1'b1, 32'hD, 1'b0, 1'b0, 32'h0, 1'b1, 2'd0, 4'd6);
        add(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 2'd0, 4'd6);
        add(1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 32'h33, 1'b1, 2'd1, 4'd6);
        add(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h33, 1'b1, 2'd0, 4'd6);
        // accept and pop together in ONE
        add(1'b0, 1'b1, 32'h5, 1'b0, 1'b1, 32'h5, 1'b1, 2'd1, 4'd6);
        add(1'b0, 1'b1, 32'h6, 1'b1, 1'b1, 32'h6, 1'b1, 2'd1, 4'd6);
        add(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h6, 1'b1, 2'd0, 4'd6);
        // flush while ONE drops a beat even though in_ready=1
        add(1'b0, 1'b1, 32'h44, 1'b0, 1'b1, 32'h44, 1'b1, 2'd1, 4'd6);
        add(1'b1, 1'b1, 32'h55, 1'b0, 1'b0, 32'h0, 1'b1, 2'd0, 4'd7);

        #2;
        check_all("reset", 1'b0, 32'h0, 1'b1, 2'd0, 4'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            flush     = vecs[i].flush;
            in_valid  = vecs[i].in_valid;
            in_data   = DW'(vecs[i].in_data);
            out_ready = vecs[i].out_ready;
            @(posedge clk);
            #1;
            check_all($sformatf("v%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                      vecs[i].exp_ready, vecs[i].exp_occ, vecs[i].exp_stall);
            @(negedge clk);
        end
        flush    = 1'b0;
        in_valid = 1'b0;

        // asynchronous reset between edges while FULL
        in_valid  = 1'b1;
        in_data   = DW'(32'hA);
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_data = DW'(32'hB);
        @(posedge clk);
        #1;
        check("pre_reset occupancy", DW'(occupancy), DW'(2'd2));
        #2;
        reset = 1'b1;
        #1;
        check_all("async_reset", 1'b0, 32'h0, 1'b1, 2'd0, 4'd0);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;

        // stall counter saturates at 2^CW-1
        in_valid = 1'b1;
        in_data  = DW'(32'h77);
        @(posedge clk);
        #1;
        check("sat load stall_cnt", DW'(stall_cnt), DW'(0));
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("sat k%0d stall_cnt", k), DW'(stall_cnt), DW'((k > 15) ? 15 : k));
            @(negedge clk);
        end
        check("sat held out_data", out_data, DW'(32'h77));
        check("sat out_valid", DW'(out_valid), DW'(1'b1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
